// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, with the key
// schedule rotated right so subkeys come out in decryption order (K16 first).
module des_decrypt_core (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [63:0] Cipher_In,
    input  logic [63:0] Key_In,
    output logic [63:0] Plain_Out,
    output logic        Busy,
    output logic        Done
);

    // Tables hold DES bit numbers (1 = MSB of the source word).
    localparam int IP_T [0:63] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Eight S-boxes, each 4 rows x 16 columns, indexed {box, row, col}.
    localparam int SBOX_T [0:511] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    typedef enum logic {IDLE, ROUND} state_t;

    state_t      state, state_nxt;
    logic [4:0]  rnd_cnt, rnd_cnt_nxt;
    logic [31:0] l_q, r_q, l_nxt, r_nxt;
    logic [27:0] c_q, d_q, c_nxt, d_nxt;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;
    logic [1:0]  rot_amt;
    logic [63:0] plain_nxt;
    logic        done_nxt;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y = {y[62:0], x[6'(64 - IP_T[k])]};
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < 64; k++) y = {y[62:0], x[6'(64 - FP_T[k])]};
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y = {y[46:0], x[5'(32 - E_T[k])]};
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) y = {y[30:0], x[5'(32 - P_T[k])]};
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int k = 0; k < 56; k++) y = {y[54:0], x[6'(64 - PC1_T[k])]};
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int k = 0; k < 48; k++) y = {y[46:0], x[6'(56 - PC2_T[k])]};
        return y;
    endfunction

    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        logic [8:0]  idx;
        y = '0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            idx = {3'(b), six[5], six[0], six[4:1]};
            y   = {y[27:0], 4'(SBOX_T[idx])};
        end
        return y;
    endfunction

    // Reverse of the encryption shift list, consumed before each subkey.
    function automatic logic [1:0] rot_sel(input logic [4:0] n);
        case (n)
            5'd1:                return 2'd0;
            5'd2, 5'd9, 5'd16:   return 2'd1;
            default:             return 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    always_comb begin
        rot_amt = rot_sel(rnd_cnt);
        c_rot   = rotr28(c_q, rot_amt);
        d_rot   = rotr28(d_q, rot_amt);
        subkey  = pc2_perm({c_rot, d_rot});
        f_out   = p_perm(sbox_sub(e_expand(r_q) ^ subkey));
    end

    always_comb begin
        state_nxt   = state;
        rnd_cnt_nxt = rnd_cnt;
        l_nxt       = l_q;
        r_nxt       = r_q;
        c_nxt       = c_q;
        d_nxt       = d_q;
        plain_nxt   = Plain_Out;
        done_nxt    = 1'b0;
        Busy        = (state == ROUND);
        case (state)
            IDLE: begin
                if (Start) begin
                    {l_nxt, r_nxt} = ip_perm(Cipher_In);
                    {c_nxt, d_nxt} = pc1_perm(Key_In);
                    rnd_cnt_nxt    = 5'd1;
                    state_nxt      = ROUND;
                end
            end
            ROUND: begin
                l_nxt = r_q;
                r_nxt = l_q ^ f_out;
                c_nxt = c_rot;
                d_nxt = d_rot;
                if (rnd_cnt == 5'd16) begin
                    // Final round output goes out unswapped: R16 || L16.
                    plain_nxt   = fp_perm({l_q ^ f_out, r_q});
                    done_nxt    = 1'b1;
                    rnd_cnt_nxt = 5'd0;
                    state_nxt   = IDLE;
                end else begin
                    rnd_cnt_nxt = rnd_cnt + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rnd_cnt   <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            Plain_Out <= '0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rnd_cnt   <= rnd_cnt_nxt;
            l_q       <= l_nxt;
            r_q       <= r_nxt;
            c_q       <= c_nxt;
            d_q       <= d_nxt;
            Plain_Out <= plain_nxt;
            Done      <= done_nxt;
        end
    end

endmodule
